// File: rtl/sap_datapath_if.sv
// rtl/sap_datapath_if.sv - control, program-port and status signals of the SAP datapath
interface sap_datapath_if;
    logic [14:0] ctrl;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic [3:0]  pc_dbg;
    logic [7:0]  out_value;
    logic        out_valid;
    logic        bus_conflict;
    logic        flag_c;
    logic        flag_z;

    modport master (
        output ctrl, prog_we, prog_addr, prog_data,
        input  opcode, pc_dbg, out_value, out_valid, bus_conflict, flag_c, flag_z
    );

    modport slave (
        input  ctrl, prog_we, prog_addr, prog_data,
        output opcode, pc_dbg, out_value, out_valid, bus_conflict, flag_c, flag_z
    );
endinterface

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP-style 8-bit datapath with shared bus; optional SAP_DP_FLAGS_EN carry/zero flags
module sap_datapath #(
    parameter string RAM_INIT_HEX = ""
) (
    input  logic         clk,
    input  logic         rst_n,
    sap_datapath_if.slave dp
);

    logic c_p, e_p, l_p, l_ma_n, l_md_n, ce_n, l_r_n, l_i_n;
    logic e_i_n, l_a_n, e_a, s_u, e_u, l_b_n, l_o_n;

    assign {c_p, e_p, l_p, l_ma_n, l_md_n, ce_n, l_r_n, l_i_n,
            e_i_n, l_a_n, e_a, s_u, e_u, l_b_n, l_o_n} = dp.ctrl;

    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] mdr;
    logic [7:0] ir;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out_q;
    logic       out_valid_q;
    logic       conflict_q;
    logic [7:0] ram [16];

    logic [7:0] bus;
    logic [7:0] alu;
    logic [8:0] sum;
    logic       carry;
    logic       eu_wins;
    logic [2:0] n_drv;
    logic       multi_drive;

    // Subtraction is A + ~B + 1, so carry set means no borrow.
    assign sum   = {1'b0, a} + {1'b0, (s_u ? ~b : b)} + {8'h00, s_u};
    assign alu   = sum[7:0];
    assign carry = sum[8];

    always_comb begin
        bus     = 8'h00;
        eu_wins = 1'b0;
        if (e_p) begin
            bus = {4'h0, pc};
        end else if (!e_i_n) begin
            bus = {4'h0, ir[3:0]};
        end else if (!ce_n) begin
            bus = ram[mar];
        end else if (e_a) begin
            bus = a;
        end else if (e_u) begin
            bus     = alu;
            eu_wins = 1'b1;
        end
    end

    assign n_drv = {2'b00, e_p} + {2'b00, ~e_i_n} + {2'b00, ~ce_n}
                 + {2'b00, e_a} + {2'b00, e_u};
    assign multi_drive = (n_drv > 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= 4'h0;
            mar         <= 4'h0;
            mdr         <= 8'h00;
            ir          <= 8'h00;
            a           <= 8'h00;
            b           <= 8'h00;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            if (l_p) begin
                pc <= bus[3:0];
            end else if (c_p) begin
                pc <= pc + 4'h1;
            end
            if (!l_ma_n) mar <= bus[3:0];
            if (!l_md_n) mdr <= bus;
            if (!l_i_n)  ir  <= bus;
            if (!l_a_n)  a   <= bus;
            if (!l_b_n)  b   <= bus;
            if (!l_o_n)  out_q <= bus;
            out_valid_q <= ~l_o_n;
            if (multi_drive) conflict_q <= 1'b1;
        end
    end

    // RAM is never reset; the program port overrides a same-cycle datapath store.
    always_ff @(posedge clk) begin
        if (dp.prog_we) begin
            ram[dp.prog_addr] <= dp.prog_data;
        end else if (!l_r_n) begin
            ram[mar] <= mdr;
        end
    end

`ifdef SAP_DP_FLAGS_EN
    logic flag_c_q;
    logic flag_z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else if (!l_a_n && eu_wins) begin
            flag_c_q <= carry;
            flag_z_q <= (alu == 8'h00);
        end
    end

    assign dp.flag_c = flag_c_q;
    assign dp.flag_z = flag_z_q;
`else
    logic unused_flag_terms;
    assign unused_flag_terms = carry ^ eu_wins;
    assign dp.flag_c = 1'b0;
    assign dp.flag_z = 1'b0;
`endif

    assign dp.opcode       = ir[7:4];
    assign dp.pc_dbg       = pc;
    assign dp.out_value    = out_q;
    assign dp.out_valid    = out_valid_q;
    assign dp.bus_conflict = conflict_q;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - directed and random checks of sap_datapath against a spec-level model
module tb_sap_datapath;

    localparam logic [14:0] IDLE = 15'h0FE3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sap_datapath_if dif ();
    sap_datapath dut (.clk(clk), .rst_n(rst_n), .dp(dif));

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] m_pc, m_mar;
    logic [7:0] m_mdr, m_ir, m_a, m_b, m_out;
    logic       m_ov, m_conf, m_fc, m_fz;
    logic [7:0] m_ram [16];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0;
        m_out = 0; m_ov = 0; m_conf = 0; m_fc = 0; m_fz = 0;
    endtask

    // Bus value from the ordered driver list: first enabled source wins.
    task automatic model_bus(input logic [14:0] c, output logic [7:0] v,
                             output logic conflict, output logic alu_wins);
        logic       en [5];
        logic [7:0] src [5];
        int         cnt;
        int         first;
        en[0] = c[13];  src[0] = {4'h0, m_pc};
        en[1] = !c[6];  src[1] = {4'h0, m_ir[3:0]};
        en[2] = !c[9];  src[2] = m_ram[m_mar];
        en[3] = c[4];   src[3] = m_a;
        en[4] = c[2];   src[4] = c[3] ? 8'(m_a - m_b) : 8'(m_a + m_b);
        cnt = 0; first = -1;
        for (int i = 0; i < 5; i++) begin
            if (en[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        v        = (first < 0) ? 8'h00 : src[first];
        conflict = (cnt > 1);
        alu_wins = (first == 4);
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".pc"},    {4'h0, dif.pc_dbg}, {4'h0, m_pc});
        chk({ctx, ".op"},    {4'h0, dif.opcode}, {4'h0, m_ir[7:4]});
        chk({ctx, ".out"},   dif.out_value, m_out);
        chk({ctx, ".ov"},    {7'h0, dif.out_valid}, {7'h0, m_ov});
        chk({ctx, ".conf"},  {7'h0, dif.bus_conflict}, {7'h0, m_conf});
        chk({ctx, ".fc"},    {7'h0, dif.flag_c}, {7'h0, m_fc});
        chk({ctx, ".fz"},    {7'h0, dif.flag_z}, {7'h0, m_fz});
        chk({ctx, ".a"},     dut.a, m_a);
        chk({ctx, ".b"},     dut.b, m_b);
        chk({ctx, ".mar"},   {4'h0, dut.mar}, {4'h0, m_mar});
        chk({ctx, ".mdr"},   dut.mdr, m_mdr);
        chk({ctx, ".ir"},    dut.ir, m_ir);
    endtask

    task automatic ram_check(input string ctx);
        for (int i = 0; i < 16; i++) chk($sformatf("%s.ram%0d", ctx, i), dut.ram[i], m_ram[i]);
    endtask

    task automatic step(input logic [14:0] c, input logic pwe = 1'b0,
                        input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
        logic [7:0] v, alu;
        logic       conflict, alu_wins, carry;
        @(negedge clk);
        dif.ctrl = c; dif.prog_we = pwe; dif.prog_addr = pa; dif.prog_data = pd;
        #1;
        model_bus(c, v, conflict, alu_wins);
        chk("bus", dut.bus, v);
        @(posedge clk);
        #1;
        alu   = c[3] ? 8'(m_a - m_b) : 8'(m_a + m_b);
        carry = c[3] ? (m_a >= m_b) : ((int'(m_a) + int'(m_b)) > 255);
        if (pwe) m_ram[pa] = pd;
        else if (!c[8]) m_ram[m_mar] = m_mdr;
        if (c[12]) m_pc = v[3:0];
        else if (c[14]) m_pc = m_pc + 4'h1;
        if (!c[11]) m_mar = v[3:0];
        if (!c[10]) m_mdr = v;
        if (!c[7])  m_ir  = v;
        if (!c[5])  m_a   = v;
        if (!c[1])  m_b   = v;
        if (!c[0])  m_out = v;
        m_ov   = !c[0];
        m_conf = m_conf | conflict;
`ifdef SAP_DP_FLAGS_EN
        if (!c[5] && alu_wins) begin
            m_fc = carry;
            m_fz = (alu == 8'h00);
        end
`else
        if (alu_wins && carry) m_fc = 1'b0;
`endif
        check_all("step");
    endtask

    task automatic prog(input logic [3:0] pa, input logic [7:0] pd);
        step(IDLE, 1'b1, pa, pd);
    endtask

    task automatic pulse_reset(input string ctx);
        @(negedge clk);
        dif.ctrl = IDLE; dif.prog_we = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        ram_check(ctx);
        #1 rst_n = 1'b1;
    endtask

    task automatic fetch();
        step(15'h27E3);
        step(15'h4FE3);
        step(15'h0D63);
    endtask

    initial begin
        dif.ctrl = IDLE; dif.prog_we = 1'b0; dif.prog_addr = 4'h0; dif.prog_data = 8'h00;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 check_all("por");
        #4 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) prog(4'(i), 8'h00);

        // Reset mid-run: A=0x55, PC=3, then async reset
        prog(4'h0, 8'h55);
        step(15'h0DC3);
        step(15'h4FE3); step(15'h4FE3); step(15'h4FE3);
        chk("pre_rst_a", dut.a, 8'h55);
        chk("pre_rst_pc", {4'h0, dif.pc_dbg}, 8'h03);
        pulse_reset("rst");
        chk("rst_ram0", dut.ram[0], 8'h55);

        // Fetch
        prog(4'h0, 8'h4E);
        fetch();
        chk("fetch_mar", {4'h0, dut.mar}, 8'h00);
        chk("fetch_pc", {4'h0, dif.pc_dbg}, 8'h01);
        chk("fetch_ir", dut.ir, 8'h4E);
        chk("fetch_op", {4'h0, dif.opcode}, 8'h04);
        chk("fetch_conf", {7'h0, dif.bus_conflict}, 8'h00);

        // LDA 14 / ADD 15 / OUT
        pulse_reset("rst2");
        prog(4'h0, 8'h4E); prog(4'h1, 8'h2F); prog(4'h2, 8'h50); prog(4'h3, 8'h00);
        prog(4'hE, 8'h05); prog(4'hF, 8'h07);
        fetch(); step(15'h07A3); step(15'h0DC3);
        fetch(); step(15'h07A3); step(15'h0DE1); step(15'h0FC7);
        fetch(); step(15'h0FF2);
        chk("prog_a", dut.a, 8'h0C);
        chk("prog_out", dif.out_value, 8'h0C);
        chk("prog_ov1", {7'h0, dif.out_valid}, 8'h01);
        step(IDLE);
        chk("prog_ov0", {7'h0, dif.out_valid}, 8'h00);

        // SUB with wrap, then SUB to zero
        prog(m_mar, 8'h03); step(15'h0DC3);
        prog(m_mar, 8'h05); step(15'h0DE1);
        step(15'h0FCF);
        chk("sub_a", dut.a, 8'hFE);
`ifdef SAP_DP_FLAGS_EN
        chk("sub_fc", {7'h0, dif.flag_c}, 8'h00);
        chk("sub_fz", {7'h0, dif.flag_z}, 8'h00);
`endif
        prog(m_mar, 8'h05); step(15'h0DC3);
        step(15'h0FCF);
        chk("sub0_a", dut.a, 8'h00);
`ifdef SAP_DP_FLAGS_EN
        chk("sub0_fc", {7'h0, dif.flag_c}, 8'h01);
        chk("sub0_fz", {7'h0, dif.flag_z}, 8'h01);
`endif

        // PC wrap and load-over-increment
        prog(m_mar, 8'h0F); step(15'h1DE3);
        step(15'h4FE3);
        chk("pc_wrap", {4'h0, dif.pc_dbg}, 8'h00);
        prog(m_mar, 8'h0F); step(15'h1DE3);
        prog(m_mar, 8'h09); step(15'h5DE3);
        chk("pc_load", {4'h0, dif.pc_dbg}, 8'h09);

        // STA, then STA colliding with the program port
        prog(m_mar, 8'h0A); step(15'h05E3);
        prog(4'hA, 8'h33); step(15'h09E3);
        prog(4'hA, 8'h11);
        step(15'h0EE3);
        chk("sta", dut.ram[10], 8'h33);
        step(15'h0EE3, 1'b1, 4'hA, 8'h77);
        chk("sta_prog", dut.ram[10], 8'h77);

        // Bus conflict: E_P and E_A together
        prog(m_mar, 8'h02); step(15'h1DE3);
        prog(m_mar, 8'h99); step(15'h0DC3);
        step(15'h2FF1);
        chk("conf_b", dut.b, 8'h02);
        chk("conf_set", {7'h0, dif.bus_conflict}, 8'h01);
        step(IDLE); step(IDLE);
        chk("conf_sticky", {7'h0, dif.bus_conflict}, 8'h01);
        ram_check("dir");

        // Random control words with occasional program-port writes
        pulse_reset("rst3");
        for (int i = 0; i < 300; i++) begin
            step(15'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
        end
        ram_check("rnd");
        pulse_reset("rst4");
        chk("conf_clr", {7'h0, dif.bus_conflict}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
